cache_ctrl: RTL
===============

Name: cache_ctrl

Overview:
- Write-back, write-allocate cache controller FSM for the set-associative cache.
- Sequences the tag/valid, data, dirty and LRU arrays on CPU requests.
- Drives the dirty array's 2-bit operation code: 00 idle/read, 01 mark, 10 unmark.
- Handshakes with physical memory for writebacks and line fills.
- Sits between the CPU-side port and the per-way array instances; contains no storage arrays itself.

Parameters:
- s_index, 4, set index width; num_sets = 2**s_index
- w_index, 2, way select width; num_ways = 2**w_index

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-low (rst==0 at posedge resets)
- cpu_read  in  1  read request, held until cpu_resp
- cpu_write  in  1  write request, held until cpu_resp
- cpu_set  in  s_index  set index of request address
- cpu_resp  out  1  one-cycle completion pulse
- hit  in  1  tag match AND valid for set_sel, combinational from arrays
- hit_way  in  w_index  matching way, meaningful when hit=1
- victim_way  in  w_index  LRU replacement way for set_sel
- dirty_out  in  1  dirty bit of (set_sel, way_sel), combinational
- dirty_op  out  2  dirty array operation code
- set_sel  out  s_index  set address to all arrays
- way_sel  out  w_index  way address to dirty/data/tag arrays
- tag_valid_we  out  1  write tag and set valid for (set_sel, way_sel)
- data_we  out  1  data array write enable
- data_sel  out  1  data source: 0 = CPU write data with byte mask; 1 = pmem line
- lru_update  out  1  touch LRU with lru_way
- lru_way  out  w_index  way being touched
- pmem_read  out  1  line fill request, level, held until pmem_resp
- pmem_write  out  1  writeback request, level, held until pmem_resp
- pmem_addr_sel  out  1  pmem address source: 0 = CPU tag/set; 1 = victim tag/set
- pmem_resp  in  1  memory completion pulse

Behaviour:
- States: IDLE, COMPARE, WB, FILL. Registers: state, set_q (s_index bits), victim_q (w_index bits).
- Output defaults: every output 0 and dirty_op=00 unless stated below.
- set_sel: equals cpu_set in IDLE; equals set_q in all other states.
- IDLE:
  - If cpu_read|cpu_write: set_q<=cpu_set, go to COMPARE.
  - If both requests are high, treat the request as a write.
- COMPARE, hit=1:
  - cpu_resp=1, lru_update=1, lru_way=hit_way, way_sel=hit_way.
  - If write: data_we=1, data_sel=0, dirty_op=01.
  - Next state IDLE.
- COMPARE, hit=0:
  - way_sel=victim_way; victim_q<=victim_way.
  - If dirty_out=1, go to WB; else go to FILL.
- WB:
  - way_sel=victim_q, pmem_write=1, pmem_addr_sel=1.
  - On pmem_resp: dirty_op=10 in that cycle, go to FILL.
- FILL:
  - way_sel=victim_q, pmem_read=1, pmem_addr_sel=0.
  - On pmem_resp: data_we=1, data_sel=1, tag_valid_we=1, dirty_op=10, go to COMPARE. The re-compare hits.
- Latency:
  - Hit: cpu_resp 1 cycle after the request is sampled in IDLE (2nd cycle of the request).
  - Clean miss: IDLE, COMPARE, FILL(n), COMPARE.
  - Dirty miss: adds WB(m) before FILL.
- victim_q is frozen from the miss until the fill completes; LRU changes mid-miss have no effect.
- pmem_resp is ignored in IDLE and COMPARE.
- pmem_read and pmem_write are never high together.
- Back-to-back requests: after a hit, IDLE samples the next request on the following cycle. No request is accepted in COMPARE.
- Reset (rst=0 at posedge):
  - state=IDLE, set_q=0, victim_q=0; all outputs 0 from the next cycle.
  - Reset in WB/FILL drops pmem_read/pmem_write in the following cycle; the memory side must tolerate the abort.

Optional Feature:
- Macro: CACHE_CTRL_PERF_EN.
- When defined:
  - Adds outputs hit_cnt, miss_cnt and wb_cnt, 32 bits each, reset to 0.
  - Counters increment on COMPARE-hit (excluding the post-fill re-compare), on COMPARE-miss, and on entering WB, respectively.
  - Counters saturate at 2^32-1.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Read hit: hit=1, cpu_read, cpu_set=5 -> cpu_resp on cycle 2, lru_update=1, lru_way=hit_way, dirty_op=00, no pmem activity.
- Write hit: hit_way=2, cpu_set=3 -> cycle 2: data_we=1, data_sel=0, dirty_op=01, way_sel=2, set_sel=3.
- Clean miss: hit=0, victim_way=1, dirty_out=0, pmem_resp after 4 cycles -> pmem_read held 4 cycles; fill cycle has tag_valid_we=1, dirty_op=10, way_sel=1; then COMPARE with hit=1 gives cpu_resp.
- Dirty miss: victim_way=3, dirty_out=1 -> pmem_write with pmem_addr_sel=1 until pmem_resp; dirty_op=10 on that cycle; then pmem_read; victim_way changed to 0 mid-miss -> way_sel stays 3.
- Reset mid-WB: rst=0 during pmem_write -> next cycle all outputs 0, state IDLE; stray pmem_resp afterwards is ignored.
- Simultaneous cpu_read=cpu_write=1 on a hit -> handled as a write (dirty_op=01); requests back-to-back on the cycle after cpu_resp are accepted.

Source files
------------

// File: rtl/cache_ctrl.sv
// Write-back, write-allocate cache controller FSM sequencing tag/data/dirty/LRU arrays and pmem.
// Optional performance counters are enabled by defining CACHE_CTRL_PERF_EN.
module cache_ctrl #(
  parameter int unsigned s_index = 4,
  parameter int unsigned w_index = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_read,
  input  logic               cpu_write,
  input  logic [s_index-1:0] cpu_set,
  output logic               cpu_resp,
  input  logic               hit,
  input  logic [w_index-1:0] hit_way,
  input  logic [w_index-1:0] victim_way,
  input  logic               dirty_out,
  output logic [1:0]         dirty_op,
  output logic [s_index-1:0] set_sel,
  output logic [w_index-1:0] way_sel,
  output logic               tag_valid_we,
  output logic               data_we,
  output logic               data_sel,
  output logic               lru_update,
  output logic [w_index-1:0] lru_way,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic               pmem_addr_sel,
`ifdef CACHE_CTRL_PERF_EN
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt,
  output logic [31:0]        wb_cnt,
`endif
  input  logic               pmem_resp
);

  typedef enum logic [1:0] {StIdle, StCompare, StWb, StFill} state_e;

  state_e             state_q, state_d;
  logic [s_index-1:0] set_q, set_d;
  logic [w_index-1:0] victim_q, victim_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      set_q    <= '0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      set_q    <= set_d;
      victim_q <= victim_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    set_d         = set_q;
    victim_d      = victim_q;
    cpu_resp      = 1'b0;
    dirty_op      = 2'b00;
    set_sel       = set_q;
    way_sel       = '0;
    tag_valid_we  = 1'b0;
    data_we       = 1'b0;
    data_sel      = 1'b0;
    lru_update    = 1'b0;
    lru_way       = '0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    unique case (state_q)
      StIdle: begin
        set_sel = cpu_set;
        if (cpu_read || cpu_write) begin
          set_d   = cpu_set;
          state_d = StCompare;
        end
      end
      StCompare: begin
        if (hit) begin
          cpu_resp   = 1'b1;
          lru_update = 1'b1;
          lru_way    = hit_way;
          way_sel    = hit_way;
          // A simultaneous read+write is served as a write.
          if (cpu_write) begin
            data_we  = 1'b1;
            dirty_op = 2'b01;
          end
          state_d = StIdle;
        end else begin
          way_sel  = victim_way;
          victim_d = victim_way;
          state_d  = dirty_out ? StWb : StFill;
        end
      end
      StWb: begin
        way_sel       = victim_q;
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        if (pmem_resp) begin
          dirty_op = 2'b10;
          state_d  = StFill;
        end
      end
      StFill: begin
        way_sel   = victim_q;
        pmem_read = 1'b1;
        if (pmem_resp) begin
          data_we      = 1'b1;
          data_sel     = 1'b1;
          tag_valid_we = 1'b1;
          dirty_op     = 2'b10;
          state_d      = StCompare;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef CACHE_CTRL_PERF_EN
  logic        refill_q, refill_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] wb_cnt_q, wb_cnt_d;
  logic        hit_inc, miss_inc, wb_inc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      refill_q   <= refill_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  // refill_q marks the re-compare that follows a fill so it is not counted as a hit.
  always_comb begin
    refill_d   = (state_q == StFill) && pmem_resp;
    hit_inc    = (state_q == StCompare) && hit && !refill_q;
    miss_inc   = (state_q == StCompare) && !hit;
    wb_inc     = miss_inc && dirty_out;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (hit_inc && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + 32'd1;
    if (miss_inc && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 32'd1;
    if (wb_inc && (wb_cnt_q != '1)) wb_cnt_d = wb_cnt_q + 32'd1;
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`endif

endmodule
